// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - Shared state encoding, word width, layer codes and output count for the activation sequencer
package act_pkg;
    localparam int WORD_W = 64;
    localparam int N_OUT  = 2;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_ACT_SEND,
        S_ACT_WAIT,
        S_MID_WR,
        S_CMP,
        S_FIN
    } state_t;
endpackage

// File: rtl/pos_dbl_cmp.sv
// rtl/pos_dbl_cmp.sv - Greater-than on positive IEEE-754 doubles
// For sign-clear doubles the bit patterns order the same way as the values, so an integer compare suffices.
module pos_dbl_cmp
    import act_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         a_gt_b_o
);
    assign a_gt_b_o = (a_i > b_i);
endmodule

// File: rtl/act_sequencer.sv
// rtl/act_sequencer.sv - Walks one sample through hidden and output neurons, writes hidden results and the class bit
module act_sequencer #(
    parameter int N_HID  = 4,
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       sample_idx,
    output logic              busy,
    output logic              done,
    output logic              acc_req,
    output logic              acc_layer,
    output logic [31:0]       acc_idx,
    input  logic              acc_valid,
    input  logic [WORD_W-1:0] acc_data,
    output logic              act_in_valid,
    input  logic              act_in_ready,
    output logic [WORD_W-1:0] act_in_data,
    input  logic              act_out_valid,
    input  logic [WORD_W-1:0] act_out_data,
    output logic              mid_we,
    output logic [31:0]       mid_addr,
    output logic [WORD_W-1:0] mid_wdata,
    output logic              cls_we,
    output logic [31:0]       cls_addr,
    output logic              cls_bit
);
    import act_pkg::*;

    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic              layer_q, layer_d;
    logic [31:0]       sample_q, sample_d;
    logic [WORD_W-1:0] operand_q, operand_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [WORD_W-1:0] out_q [N_OUT];
    logic [WORD_W-1:0] out_d [N_OUT];
    logic              a_gt_b;

    pos_dbl_cmp #(.W(WORD_W)) u_cmp (
        .a_i      (out_q[0]),
        .b_i      (out_q[1]),
        .a_gt_b_o (a_gt_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            layer_q   <= LAYER_HID;
            sample_q  <= '0;
            operand_q <= '0;
            result_q  <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            layer_q   <= layer_d;
            sample_q  <= sample_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        layer_d      = layer_q;
        sample_d     = sample_q;
        operand_d    = operand_q;
        result_d     = result_q;
        out_d        = out_q;
        busy         = 1'b0;
        done         = 1'b0;
        acc_req      = 1'b0;
        acc_layer    = 1'b0;
        acc_idx      = '0;
        act_in_valid = 1'b0;
        act_in_data  = '0;
        mid_we       = 1'b0;
        mid_addr     = '0;
        mid_wdata    = '0;
        cls_we       = 1'b0;
        cls_addr     = '0;
        cls_bit      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sample_d = sample_idx;
                    n_d      = '0;
                    layer_d  = LAYER_HID;
                    state_d  = S_ACC;
                end
            end
            S_ACC: begin
                busy      = 1'b1;
                acc_req   = 1'b1;
                acc_layer = layer_q;
                acc_idx   = n_q;
                if (acc_valid) begin
                    operand_d = acc_data;
                    state_d   = S_ACT_SEND;
                end
            end
            S_ACT_SEND: begin
                busy         = 1'b1;
                act_in_valid = 1'b1;
                act_in_data  = operand_q;
                if (act_in_ready) state_d = S_ACT_WAIT;
            end
            S_ACT_WAIT: begin
                busy = 1'b1;
                if (act_out_valid) begin
                    if (layer_q == LAYER_HID) begin
                        result_d = act_out_data;
                        state_d  = S_MID_WR;
                    end else begin
                        out_d[n_q[0]] = act_out_data;
                        if (n_q == 32'd1) begin
                            state_d = S_CMP;
                        end else begin
                            n_d     = 32'd1;
                            state_d = S_ACC;
                        end
                    end
                end
            end
            S_MID_WR: begin
                busy      = 1'b1;
                mid_we    = 1'b1;
                mid_addr  = n_q;
                mid_wdata = result_q;
                if (n_q == 32'(N_HID - 1)) begin
                    layer_d = LAYER_OUT;
                    n_d     = '0;
                end else begin
                    n_d = n_q + 32'd1;
                end
                state_d = S_ACC;
            end
            S_CMP: begin
                busy     = 1'b1;
                cls_we   = 1'b1;
                cls_addr = sample_q;
                cls_bit  = ~a_gt_b;
                state_d  = S_FIN;
            end
            S_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs stay quiet during reset so an abort can never leak a write pulse.
        if (rst) begin
            busy         = 1'b0;
            done         = 1'b0;
            acc_req      = 1'b0;
            acc_layer    = 1'b0;
            acc_idx      = '0;
            act_in_valid = 1'b0;
            act_in_data  = '0;
            mid_we       = 1'b0;
            mid_addr     = '0;
            mid_wdata    = '0;
            cls_we       = 1'b0;
            cls_addr     = '0;
            cls_bit      = 1'b0;
        end
    end
endmodule

// File: doc/act_sequencer.md
ACT_SEQUENCER -- requirements
Module: act_sequencer

Interface
REQ-001 SHALL have parameter N_HID, default 4, meaning hidden-layer neuron count (1..256).
REQ-002 SHALL have parameter WORD_W, default 64, meaning IEEE-754 double data width.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have ports start (in, 1, begin one sample), sample_idx (in, 32, sample number i), busy (out, 1), done (out, 1, one-cycle pulse).
REQ-005 SHALL have accumulator ports acc_req (out, 1), acc_layer (out, 1, 0 hidden / 1 output), acc_idx (out, 32), acc_valid (in, 1), acc_data (in, WORD_W).
REQ-006 SHALL have activation ports act_in_valid (out, 1), act_in_ready (in, 1), act_in_data (out, WORD_W), act_out_valid (in, 1), act_out_data (in, WORD_W).
REQ-007 SHALL have ports mid_we (out, 1), mid_addr (out, 32), mid_wdata (out, WORD_W) for the hidden-result buffer.
REQ-008 SHALL have ports cls_we (out, 1), cls_addr (out, 32), cls_bit (out, 1) for the classification result.

Function
REQ-009 SHALL implement the states IDLE, ACC, ACT_SEND, ACT_WAIT, MID_WR, CMP, and FIN.
REQ-010 IDLE: start=1 SHALL latch sample_idx, clear neuron counter n and layer L, and enter ACC next cycle; start while not IDLE SHALL be ignored.
REQ-011 ACC: acc_req=1 with acc_layer=L and acc_idx=n held stable; on acc_valid=1, SHALL capture acc_data into operand register and go ACT_SEND.
REQ-012 ACT_SEND: act_in_valid=1 with act_in_data=operand held stable until act_in_ready=1; transfer cycle SHALL go ACT_WAIT.
REQ-013 ACT_WAIT: on act_out_valid=1, SHALL capture act_out_data; go MID_WR if L=0, else store into out_reg[n] and go CMP if n=1, else ACC with n=1.
REQ-014 MID_WR: SHALL assert mid_we for exactly one cycle with mid_addr=n and mid_wdata=captured value; if n=N_HID-1, SHALL set L=1 and n=0, else n=n+1; then go ACC.
REQ-015 CMP: cls_bit=0 if out_reg[0] > out_reg[1] else 1 (ties give 1), cls_addr=latched sample_idx, cls_we=1 for one cycle; go FIN.
REQ-016 The comparison SHALL be an unsigned compare of the 64-bit patterns; this is valid because sigmoid outputs are positive doubles, and no floating-point hardware SHALL be used.
REQ-017 FIN: done=1 for one cycle; return IDLE; busy SHALL be 1 in every state except IDLE.
REQ-018 acc_valid or act_out_valid outside its waiting state SHALL be ignored; act_in_ready outside ACT_SEND SHALL be ignored.
REQ-019 Minimum latency with same-cycle responders SHALL be 1 + 4*N_HID + 3*2 + 2 cycles from start to done (N_HID=4 gives 25).
REQ-020 At most one request SHALL be outstanding at a time; requests SHALL NOT overlap.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, n=0, L=0, and clear operand and out_reg registers.
REQ-022 All outputs SHALL be 0 while in reset and in IDLE.
REQ-023 Reset mid-sample SHALL abort without issuing further mid_we or cls_we pulses.

Structure
REQ-024 A shared package act_pkg SHALL hold the state enum, WORD_W, the layer codes LAYER_HID=0 and LAYER_OUT=1, and the output count N_OUT=2.
REQ-025 A sub-module pos_dbl_cmp (combinational a>b on positive doubles) SHALL be instantiated for CMP; the rest SHALL be flat.

Verification
REQ-026 N_HID=4 with zero-delay responders, start, sample_idx=7 -> mid_we at addr 0,1,2,3 in order, cls_we with cls_addr=7, done 25 cycles after start.
REQ-027 Output activations 0x3FE8000000000000 (0.75) vs 0x3FE0000000000000 (0.5) -> cls_bit=0; swapped -> cls_bit=1; equal -> cls_bit=1.
REQ-028 act_in_ready held low for 5 cycles -> act_in_valid and act_in_data stable for those cycles, latency grows by exactly 5.
REQ-029 rst pulsed in ACT_WAIT of hidden neuron 2 -> next cycle IDLE, busy=0, no further mid_we or cls_we; a later start completes normally.
REQ-030 start re-pulsed while busy and spurious acc_valid during ACT_WAIT -> both ignored, and the write sequence is identical to REQ-026.
